// File: rtl/pipe_rate_ctrl.sv
// PIPE rate-change sequencer: quiesces Tx, drives the new Rate, waits for PhyStatus, then acks.
// Optional PhyStatus timeout into an error/rollback state is enabled by defining PIPE_RATE_TIMEOUT_EN.
module pipe_rate_ctrl #(
    parameter int unsigned QUIESCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RateReq,
    input  logic [2:0] ReqGEN,
    input  logic       PhyStatus,
    output logic [2:0] Rate,
    output logic [2:0] GEN,
    output logic       TxElecIdleReq,
    output logic       RxGate,
    output logic       Busy,
    output logic       ReqAck,
    output logic       ReqErr
);

    typedef enum logic [2:0] {
        StIdle,
        StQuiesce,
        StRateChg,
        StDone,
        StErr
    } state_e;

    localparam logic [15:0] QuiesceLast = 16'(QUIESCE_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
`ifdef PIPE_RATE_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  target_q, target_d;
    logic [2:0]  old_q, old_d;
    logic [2:0]  rate_q, rate_d;
    logic [2:0]  gen_q, gen_d;
    logic        txi_q, txi_d;
    logic        rxg_q, rxg_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        req_valid;

    assign req_valid = (ReqGEN >= 3'd1) && (ReqGEN <= 3'd5);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        old_d    = old_q;
        rate_d   = rate_q;
        gen_d    = gen_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (RateReq) begin
                    if (!req_valid) begin
                        err_d = 1'b1;
                    end else if (ReqGEN == gen_q) begin
                        ack_d = 1'b1;
                    end else begin
                        target_d = ReqGEN;
                        old_d    = gen_q;
                        cnt_d    = '0;
                        state_d  = StQuiesce;
                    end
                end
            end
            StQuiesce: begin
                if (cnt_q == QuiesceLast) begin
                    cnt_d   = '0;
                    rate_d  = target_q - 3'd1;
                    state_d = StRateChg;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRateChg: begin
                // PhyStatus wins over a timeout landing in the same cycle.
                if (PhyStatus) begin
                    gen_d   = target_q;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StDone;
                end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                    rate_d  = old_q - 3'd1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StErr;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        txi_d  = (state_d == StQuiesce) || (state_d == StRateChg);
        rxg_d  = (state_d == StQuiesce) || (state_d == StRateChg) || (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            target_q <= 3'd1;
            old_q    <= 3'd1;
            rate_q   <= 3'd0;
            gen_q    <= 3'd1;
            txi_q    <= 1'b0;
            rxg_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            old_q    <= old_d;
            rate_q   <= rate_d;
            gen_q    <= gen_d;
            txi_q    <= txi_d;
            rxg_q    <= rxg_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign Rate          = rate_q;
    assign GEN           = gen_q;
    assign TxElecIdleReq = txi_q;
    assign RxGate        = rxg_q;
    assign Busy          = busy_q;
    assign ReqAck        = ack_q;
    assign ReqErr        = err_q;

endmodule

// File: tb/tb_pipe_rate_ctrl.sv
// Self-checking bench for pipe_rate_ctrl: IDLE vector table, directed corner sequences and
// randomized transactions checked against a cycle-offset model of a rate change.
module tb_pipe_rate_ctrl;

    localparam int Q    = 4;
    localparam int TOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       RateReq;
    logic [2:0] ReqGEN;
    logic       PhyStatus;
    logic [2:0] Rate;
    logic [2:0] GEN;
    logic       TxElecIdleReq;
    logic       RxGate;
    logic       Busy;
    logic       ReqAck;
    logic       ReqErr;

    int n_tests = 0;
    int n_fail  = 0;
    int m_gen   = 1;

    pipe_rate_ctrl #(
        .QUIESCE_CYCLES(Q),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RateReq      (RateReq),
        .ReqGEN       (ReqGEN),
        .PhyStatus    (PhyStatus),
        .Rate         (Rate),
        .GEN          (GEN),
        .TxElecIdleReq(TxElecIdleReq),
        .RxGate       (RxGate),
        .Busy         (Busy),
        .ReqAck       (ReqAck),
        .ReqErr       (ReqErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [2:0] gen;
        logic       phy;
        logic       exp_ack;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int rate, input int gen, input int txi,
                           input int rxg, input int busy, input int ack, input int err);
        chk({tag, ".Rate"}, 16'(Rate), 16'(rate));
        chk({tag, ".GEN"}, 16'(GEN), 16'(gen));
        chk({tag, ".TxElecIdleReq"}, 16'(TxElecIdleReq), 16'(txi));
        chk({tag, ".RxGate"}, 16'(RxGate), 16'(rxg));
        chk({tag, ".Busy"}, 16'(Busy), 16'(busy));
        chk({tag, ".ReqAck"}, 16'(ReqAck), 16'(ack));
        chk({tag, ".ReqErr"}, 16'(ReqErr), 16'(err));
    endtask

    task automatic exp_idle(input string tag, input int ack, input int err);
        chk_out(tag, m_gen - 1, m_gen, 0, 0, 0, ack, err);
    endtask

    // One request from IDLE; noise: 0 none, 1 random, 2 PhyStatus held through QUIESCE.
    task automatic run_txn(input string tag, input int g, input int d, input int noise);
        int old;
        RateReq = 1'b1;
        ReqGEN  = 3'(g);
        step();
        RateReq = 1'b0;
        ReqGEN  = 3'($urandom_range(0, 7));
        if (g < 1 || g > 5) begin
            exp_idle({tag, ".inv"}, 0, 1);
            step();
            exp_idle({tag, ".inv_after"}, 0, 0);
        end else if (g == m_gen) begin
            exp_idle({tag, ".same"}, 1, 0);
            step();
            exp_idle({tag, ".same_after"}, 0, 0);
        end else begin
            old = m_gen;
            for (int k = 1; k <= Q; k++) begin
                chk_out($sformatf("%s.q%0d", tag, k), old - 1, old, 1, 1, 1, 0, 0);
                PhyStatus = (noise == 2) || (noise == 1 && $urandom_range(0, 1) == 1);
                step();
            end
            PhyStatus = 1'b0;
            for (int k = 1; k <= d; k++) begin
                chk_out($sformatf("%s.rc%0d", tag, k), g - 1, old, 1, 1, 1, 0, 0);
                PhyStatus = (k == d);
                step();
            end
            PhyStatus = 1'b0;
            chk_out({tag, ".done"}, g - 1, g, 0, 1, 1, 1, 0);
            m_gen = g;
            step();
            exp_idle({tag, ".idle"}, 0, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{req: 1'b1, gen: 3'd0, phy: 1'b0, exp_ack: 1'b0, exp_err: 1'b1};
        vecs[1] = '{req: 1'b1, gen: 3'd6, phy: 1'b0, exp_ack: 1'b0, exp_err: 1'b1};
        vecs[2] = '{req: 1'b1, gen: 3'd7, phy: 1'b1, exp_ack: 1'b0, exp_err: 1'b1};
        vecs[3] = '{req: 1'b1, gen: 3'd1, phy: 1'b0, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[4] = '{req: 1'b1, gen: 3'd1, phy: 1'b1, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[5] = '{req: 1'b0, gen: 3'd3, phy: 1'b1, exp_ack: 1'b0, exp_err: 1'b0};
        vecs[6] = '{req: 1'b0, gen: 3'd0, phy: 1'b0, exp_ack: 1'b0, exp_err: 1'b0};
        vecs[7] = '{req: 1'b0, gen: 3'd5, phy: 1'b0, exp_ack: 1'b0, exp_err: 1'b0};

        reset     = 1'b1;
        RateReq   = 1'b0;
        ReqGEN    = 3'd0;
        PhyStatus = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_gen = 1;
        exp_idle("post_reset", 0, 0);

        // IDLE decisions at GEN=1, including PhyStatus noise.
        for (int i = 0; i < 8; i++) begin
            RateReq   = vecs[i].req;
            ReqGEN    = vecs[i].gen;
            PhyStatus = vecs[i].phy;
            step();
            RateReq   = 1'b0;
            PhyStatus = 1'b0;
            exp_idle($sformatf("vec%0d", i), int'(vecs[i].exp_ack), int'(vecs[i].exp_err));
            step();
            exp_idle($sformatf("vec%0d_after", i), 0, 0);
        end

        // GEN1 -> GEN5 with PhyStatus at cycle 10.
        run_txn("gen5", 5, 6, 0);
        run_txn("back1", 1, 3, 0);

        // Request held high through DONE is re-evaluated in the first IDLE cycle.
        RateReq = 1'b1;
        ReqGEN  = 3'd2;
        step();
        for (int k = 1; k <= Q; k++) begin
            chk_out($sformatf("hold.q%0d", k), 0, 1, 1, 1, 1, 0, 0);
            step();
        end
        chk_out("hold.rc", 1, 1, 1, 1, 1, 0, 0);
        PhyStatus = 1'b1;
        step();
        PhyStatus = 1'b0;
        chk_out("hold.done", 1, 2, 0, 1, 1, 1, 0);
        step();
        chk_out("hold.idle", 1, 2, 0, 0, 0, 0, 0);
        step();
        chk_out("hold.reack", 1, 2, 0, 0, 0, 1, 0);
        RateReq = 1'b0;
        step();
        m_gen = 2;
        exp_idle("hold.end", 0, 0);

`ifdef PIPE_RATE_TIMEOUT_EN
        run_txn("to_setup", 1, 2, 0);
        RateReq = 1'b1;
        ReqGEN  = 3'd3;
        step();
        RateReq = 1'b0;
        for (int k = 1; k <= Q; k++) begin
            chk_out($sformatf("to.q%0d", k), 0, 1, 1, 1, 1, 0, 0);
            step();
        end
        for (int k = 1; k <= TOUT; k++) begin
            chk_out($sformatf("to.rc%0d", k), 2, 1, 1, 1, 1, 0, 0);
            step();
        end
        chk_out("to.err", 0, 1, 0, 0, 1, 0, 1);
        step();
        exp_idle("to.idle", 0, 0);
        // PhyStatus on the timeout cycle must win.
        run_txn("to_prio", 3, TOUT, 0);
`else
        // PhyStatus during QUIESCE is ignored; RATE_CHG waits well past any timeout.
        run_txn("no_to", 4, 41, 2);
`endif

        // Asynchronous reset during RATE_CHG.
        RateReq = 1'b1;
        ReqGEN  = (m_gen == 4) ? 3'd2 : 3'd4;
        step();
        RateReq = 1'b0;
        repeat (Q + 2) step();
        chk("rst.busy_before", 16'(Busy), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst.async", 0, 1, 0, 0, 0, 0, 0);
        step();
        chk_out("rst.held", 0, 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        m_gen = 1;
        for (int k = 0; k < 3; k++) begin
            PhyStatus = (k == 0);
            step();
            exp_idle($sformatf("rst.after%0d", k), 0, 0);
        end
        PhyStatus = 1'b0;
        run_txn("rst.resume", 3, 2, 0);

        for (int i = 0; i < 30; i++) begin
            run_txn($sformatf("rnd%0d", i), $urandom_range(0, 7), $urandom_range(1, 12), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
